time_setter: RTL

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/time_setter.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/time_setter.sv
// Push-button time editor: captures live BCD time, steps hour/minute fields, and offers the result as a load.
// Optional 12-hour editing with an AM/PM field is enabled by defining TIME_SETTER_12HR_EN.
module time_setter (
    input  logic       clkdvd,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] cur_hr_tens,
    input  logic [3:0] cur_hr_ones,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_ones,
    input  logic       ld_ready,
    output logic       ld_valid,
    output logic [3:0] ld_hr_tens,
    output logic [3:0] ld_hr_ones,
    output logic [3:0] ld_min_tens,
    output logic [3:0] ld_min_ones,
    output logic [1:0] field,
    output logic       blink
);

    localparam int unsigned TIMEOUT = 30;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned HR_W    = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned BTN_N   = 3;

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HR,
        EDIT_MIN,
`ifdef TIME_SETTER_12HR_EN
        EDIT_AMPM,
`endif
        COMMIT
    } state_t;

    function automatic logic [5:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        return 6'(tens) * 6'd10 + 6'(ones);
    endfunction

    // Repeated subtraction keeps this to a handful of comparators for values below 60.
    function automatic logic [7:0] bin2bcd(input logic [5:0] b);
        logic [5:0] r;
        logic [3:0] t;
        r = b;
        t = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        return {t, 4'(r)};
    endfunction

    function automatic logic is_edit(input state_t s);
        logic e;
        e = (s == EDIT_HR) || (s == EDIT_MIN);
`ifdef TIME_SETTER_12HR_EN
        e = e || (s == EDIT_AMPM);
`endif
        return e;
    endfunction

`ifdef TIME_SETTER_12HR_EN
    function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] h);
        return (h == 5'd12) ? 5'd1 : h + 5'd1;
    endfunction

    function automatic logic [HR_W-1:0] hr_dec(input logic [HR_W-1:0] h);
        return (h == 5'd1) ? 5'd12 : h - 5'd1;
    endfunction

    // Returns {pm, hour12}.
    function automatic logic [HR_W:0] to_12h(input logic [HR_W-1:0] h);
        if (h == 5'd0)       return {1'b0, 5'd12};
        else if (h < 5'd12)  return {1'b0, h};
        else if (h == 5'd12) return {1'b1, 5'd12};
        else                 return {1'b1, h - 5'd12};
    endfunction

    function automatic logic [HR_W-1:0] to_24h(input logic [HR_W-1:0] h, input logic pm);
        if (h == 5'd12) return pm ? 5'd12 : 5'd0;
        else            return pm ? h + 5'd12 : h;
    endfunction
`else
    function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [HR_W-1:0] hr_dec(input logic [HR_W-1:0] h);
        return (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction
`endif

    function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    function automatic logic [MIN_W-1:0] min_dec(input logic [MIN_W-1:0] m);
        return (m == 6'd0) ? 6'd59 : m - 6'd1;
    endfunction

    // Button synchronizers: bit 2 mode, bit 1 up, bit 0 down.
    logic [BTN_N-1:0] sync1_q, sync2_q, prev_q, btn_edge;
    logic             mode_e, up_e, down_e;

    always_ff @(posedge clkdvd) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {btn_mode, btn_up, btn_down};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign btn_edge = sync2_q & ~prev_q;
    assign mode_e   = btn_edge[2];
    assign up_e     = btn_edge[1];
    assign down_e   = btn_edge[0];

    state_t           state_q, state_d;
    logic [HR_W-1:0]  hr_q, hr_d, hr24_d, cur_hr_bin;
    logic [MIN_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accepted, up_only, down_only;
    logic             ld_valid_d, blink_d;
    logic [1:0]       field_d;
    logic [7:0]       ld_hr_d, ld_min_d;
`ifdef TIME_SETTER_12HR_EN
    logic             pm_q, pm_d;
`endif

    assign cur_hr_bin = HR_W'(bcd2bin(cur_hr_tens, cur_hr_ones));

    always_ff @(posedge clkdvd) begin
        if (reset) begin
            state_q     <= IDLE;
            hr_q        <= '0;
            min_q       <= '0;
            cnt_q       <= '0;
            ld_valid    <= 1'b0;
            ld_hr_tens  <= '0;
            ld_hr_ones  <= '0;
            ld_min_tens <= '0;
            ld_min_ones <= '0;
            field       <= '0;
            blink       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            cnt_q       <= cnt_d;
            ld_valid    <= ld_valid_d;
            ld_hr_tens  <= ld_hr_d[7:4];
            ld_hr_ones  <= ld_hr_d[3:0];
            ld_min_tens <= ld_min_d[7:4];
            ld_min_ones <= ld_min_d[3:0];
            field       <= field_d;
            blink       <= blink_d;
        end
    end

`ifdef TIME_SETTER_12HR_EN
    always_ff @(posedge clkdvd) begin
        if (reset) pm_q <= 1'b0;
        else       pm_q <= pm_d;
    end
`endif

    // Next state, edit registers, idle timeout and registered output values.
    always_comb begin
        state_d   = state_q;
        hr_d      = hr_q;
        min_d     = min_q;
        cnt_d     = cnt_q;
        accepted  = 1'b0;
        up_only   = up_e & ~down_e;
        down_only = down_e & ~up_e;
`ifdef TIME_SETTER_12HR_EN
        pm_d      = pm_q;
`endif

        case (state_q)
            IDLE: begin
                if (mode_e) begin
                    state_d = EDIT_HR;
                    cnt_d   = '0;
`ifdef TIME_SETTER_12HR_EN
                    {pm_d, hr_d} = to_12h(cur_hr_bin);
`else
                    hr_d    = cur_hr_bin;
`endif
                    min_d   = bcd2bin(cur_min_tens, cur_min_ones);
                end
            end
            EDIT_HR: begin
                accepted = mode_e | up_only | down_only;
                if (mode_e)         state_d = EDIT_MIN;
                else if (up_only)   hr_d = hr_inc(hr_q);
                else if (down_only) hr_d = hr_dec(hr_q);
            end
            EDIT_MIN: begin
                accepted = mode_e | up_only | down_only;
`ifdef TIME_SETTER_12HR_EN
                if (mode_e)         state_d = EDIT_AMPM;
`else
                if (mode_e)         state_d = COMMIT;
`endif
                else if (up_only)   min_d = min_inc(min_q);
                else if (down_only) min_d = min_dec(min_q);
            end
`ifdef TIME_SETTER_12HR_EN
            EDIT_AMPM: begin
                accepted = mode_e | up_only | down_only;
                if (mode_e)                     state_d = COMMIT;
                else if (up_only || down_only)  pm_d = ~pm_q;
            end
`endif
            COMMIT: begin
                if (ld_valid && ld_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abandon the edit after TIMEOUT cycles without an accepted press.
        if (is_edit(state_q)) begin
            if (accepted) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        ld_valid_d = (state_d == COMMIT);
        blink_d    = is_edit(state_d) ? ~blink : 1'b0;
        case (state_d)
            EDIT_HR:   field_d = 2'd1;
            EDIT_MIN:  field_d = 2'd2;
`ifdef TIME_SETTER_12HR_EN
            EDIT_AMPM: field_d = 2'd3;
`endif
            default:   field_d = 2'd0;
        endcase

`ifdef TIME_SETTER_12HR_EN
        hr24_d = to_24h(hr_d, pm_d);
`else
        hr24_d = hr_d;
`endif
        ld_hr_d  = bin2bcd(MIN_W'(hr24_d));
        ld_min_d = bin2bcd(min_d);
    end

endmodule
